morse_encoder: RTL

MORSE_ENCODER -- requirements
Module: morse_encoder

---
 rtl/morse_encoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/morse_encoder.sv
// Morse letter encoder: serialises up to four dot/line symbols onto an active-low key line.
// Define MORSE_ENCODER_LETTER_GAP_EN for a 3-unit letter gap; otherwise the gap is 1 unit.
module morse_encoder #(
    parameter int unsigned UNIT_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_len,
    input  logic [3:0] in_pattern,
    output logic       morse_out,
    output logic       sym_done,
    output logic       busy
);

`ifdef MORSE_ENCODER_LETTER_GAP_EN
    localparam int unsigned GapUnits = 3;
`else
    localparam int unsigned GapUnits = 1;
`endif

    localparam logic [9:0] UnitLen = 10'(UNIT_CYCLES);
    localparam logic [9:0] LineLen = 10'(3 * UNIT_CYCLES);
    localparam logic [9:0] GapLen  = 10'(GapUnits * UNIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace,
        StGap
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] len_q, len_d;
    logic [3:0] pat_q, pat_d;
    logic [9:0] dur;
    logic       last;

    // Length of the current state in clock cycles.
    always_comb begin
        case (state_q)
            StMark:  dur = pat_q[idx_q[1:0]] ? LineLen : UnitLen;
            StSpace: dur = UnitLen;
            StGap:   dur = GapLen;
            default: dur = UnitLen;
        endcase
    end

    assign last = (cnt_q == dur - 10'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        len_d     = len_q;
        pat_d     = pat_q;
        morse_out = 1'b1;
        sym_done  = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
                if (in_valid) begin
                    len_d   = (in_len > 3'd4) ? 3'd4 : in_len;
                    pat_d   = in_pattern;
                    state_d = (in_len == 3'd0) ? StGap : StMark;
                end
            end
            StMark: begin
                morse_out = 1'b0;
                if (last) begin
                    sym_done = 1'b1;
                    cnt_d    = '0;
                    if (idx_q + 3'd1 < len_q) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSpace;
                    end else begin
                        state_d = StGap;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StSpace: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = StMark;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StGap: begin
                if (last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
        end
    end

endmodule
